spi_cmd_controller: RTL and testbench
=====================================

# spi_cmd_controller

Command sequencer between `spi_slave` and the video pipeline's configuration state. It consumes the byte stream delivered by `spi_slave` (`byte_out`/`byte_ready`) and frames it with `spi_ss`. It decodes multi-byte commands and commits whole words into a bank of configuration registers that the rest of the design reads continuously. Malformed or truncated frames never partially update a register; they are counted and discarded.

## Interface
- `REG_COUNT`, default 8: number of configuration registers (≤16).
- `DATA_W`, default 16: register width; a multiple of 8.

- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `spi_ss`  in  1: slave select, active low, already synchronous to `clk`; high = no frame.
- `byte_out`  in  8: received byte from `spi_slave`; stable while `byte_ready` is high.
- `byte_ready`  in  1: high for ≥1 `clk` per received byte; only its rising edge is used.
- `cfg_flat`  out  REG_COUNT*DATA_W: register bank; register i at bits [i*DATA_W +: DATA_W].
- `reg_we`  out  1: one-cycle strobe on each committed write.
- `reg_addr`  out  4: address of the last committed write.
- `reg_wdata`  out  DATA_W: data of the last committed write.
- `err_count`  out  8: saturating count of rejected or aborted commands.
- `cmd_count`  out  8: wrapping count of successfully executed commands.

## Operation
- Byte event: `byte_ready` high while the delayed copy `rdy_q` is low. Exactly one event occurs per rising edge.
- Commands (first byte of frame, or first byte after a completed command in the same frame):
  - `0x00` NOP. Counts as executed.
  - `0x1A` WRITE to register A = bits[3:0]. Followed by DATA_W/8 data bytes, MSB first.
  - `0x2X` CLEAR. All registers go to 0, with no `reg_we` strobe. Counts as executed.
  - Any other value, or WRITE with A ≥ REG_COUNT, is an error. It increments `err_count` and sends the FSM to DISCARD.
- FSM states:
  - IDLE: `spi_ss` high. Goes to CMD when `spi_ss` is low.
  - CMD: waits for a byte event and decodes it. WRITE goes to DATA with the byte counter at 0. NOP and CLEAR stay in CMD. Errors go to DISCARD.
  - DATA: each event shifts the byte into the staging register and increments the counter. On the last byte it commits and returns to CMD.
  - DISCARD: ignores all bytes. Goes to IDLE when `spi_ss` goes high.
- From any state, `spi_ss` high forces IDLE.
  - If this happens in DATA, the staged word is dropped and `err_count` increments.
  - Errors already counted on entry to DISCARD are not counted again.
- Commit: `cfg_flat[A]`, `reg_addr`, and `reg_wdata` all update on the same edge. `reg_we` is high for that one cycle. `cmd_count` increments.
- `err_count` saturates at 255. `cmd_count` wraps from 255 to 0.
- Staging register: DATA_W bits, shift-left by 8. Not visible at the outputs.

## Timing
- Reset values: state IDLE, `cfg_flat`=0, `reg_we`=0, `reg_addr`=0, `reg_wdata`=0, both counters 0. `rdy_q` resets to 1, so a `byte_ready` level held through reset is not an event.
- Latency: `byte_ready` rises before edge N, so the event is seen at edge N. The decode, shift, or commit result is visible after edge N.
  - Write timing: `reg_we` is high in the cycle after the edge that sampled the final data byte, and `cfg_flat` already holds the new value in that cycle.
- Simultaneous `spi_ss` high and a byte event: `spi_ss` wins. The byte is dropped and the abort rule applies.
- Simultaneous `rst` and any event: reset wins.
- No backpressure: the controller accepts an event on every cycle.

## Test plan
- Reset, then frame {0x13, 0xAB, 0xCD}: `reg_we` pulses once with `reg_addr`=3 and `reg_wdata`=0xABCD. `cfg_flat[63:48]`=0xABCD. `cmd_count`=1, `err_count`=0.
- One frame {0x10, 0x12, 0x34, 0x00, 0x17, 0xFF, 0xEE}: reg0=0x1234 and reg7=0xFFEE. `cmd_count`=3.
- Frame {0x12, 0x55}, then `spi_ss` goes high: reg2 is unchanged, no `reg_we`, `err_count`=1. A following frame {0x12, 0x55, 0x66} writes 0x5566.
- Frame {0x18, 0x01, 0x02} with REG_COUNT=8: `err_count`=1, no write. Frame {0x7F, 0x10, 0xAA, 0xBB}: `err_count`=2 and all trailing bytes are ignored.
- Write non-zero values to all registers, then frame {0x2F}: `cfg_flat`=0, `reg_we` stays low.
- Hold `byte_ready` high across reset release: no event. Send 300 invalid single-byte frames: `err_count` stops at 255.

Source files
------------

// File: rtl/spi_cmd_controller.sv
// Frames the spi_slave byte stream into commands and commits whole words into a
// bank of configuration registers; malformed or truncated frames are counted and dropped.
module spi_cmd_controller #(
    parameter int REG_COUNT = 8,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        spi_ss,
    input  logic [7:0]                  byte_out,
    input  logic                        byte_ready,
    output logic [REG_COUNT*DATA_W-1:0] cfg_flat,
    output logic                        reg_we,
    output logic [3:0]                  reg_addr,
    output logic [DATA_W-1:0]           reg_wdata,
    output logic [7:0]                  err_count,
    output logic [7:0]                  cmd_count
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;

    state_t              state;
    logic                rdy_q;
    logic [CNT_W-1:0]    byte_cnt;
    logic [DATA_W-1:0]   stage;
    logic [3:0]          wr_addr;
    logic [DATA_W-1:0]   cfg_mem [REG_COUNT];

    logic                byte_evt;
    logic [DATA_W-1:0]   word_next;
    logic                addr_ok;
    logic [7:0]          err_inc;

    assign byte_evt  = byte_ready & ~rdy_q;
    assign word_next = (stage << 8) | DATA_W'(byte_out);
    assign addr_ok   = 32'(byte_out[3:0]) < 32'(REG_COUNT);
    assign err_inc   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
        assign cfg_flat[g*DATA_W +: DATA_W] = cfg_mem[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdy_q     <= 1'b1;
            byte_cnt  <= '0;
            stage     <= '0;
            wr_addr   <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_count <= '0;
            cmd_count <= '0;
            for (int unsigned i = 0; i < REG_COUNT; i++) cfg_mem[i] <= '0;
        end else begin
            rdy_q  <= byte_ready;
            reg_we <= 1'b0;
            // Deselect overrides everything, including a byte event in the same cycle.
            if (spi_ss) begin
                if (state == DATA) err_count <= err_inc;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= CMD;
                    CMD: begin
                        if (byte_evt) begin
                            if (byte_out == 8'h00) begin
                                cmd_count <= cmd_count + 8'd1;
                            end else if (byte_out[7:4] == 4'h1 && addr_ok) begin
                                wr_addr  <= byte_out[3:0];
                                byte_cnt <= '0;
                                state    <= DATA;
                            end else if (byte_out[7:4] == 4'h2) begin
                                for (int unsigned i = 0; i < REG_COUNT; i++) cfg_mem[i] <= '0;
                                cmd_count <= cmd_count + 8'd1;
                            end else begin
                                err_count <= err_inc;
                                state     <= DISCARD;
                            end
                        end
                    end
                    DATA: begin
                        if (byte_evt) begin
                            stage <= word_next;
                            if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                                for (int unsigned i = 0; i < REG_COUNT; i++)
                                    if (wr_addr == 4'(i)) cfg_mem[i] <= word_next;
                                reg_addr  <= wr_addr;
                                reg_wdata <= word_next;
                                reg_we    <= 1'b1;
                                cmd_count <= cmd_count + 8'd1;
                                state     <= CMD;
                            end else begin
                                byte_cnt <= byte_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DISCARD: state <= DISCARD;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Bench for spi_cmd_controller: directed and random frames checked against a
// frame-level parser model of the command protocol.
module tb_spi_cmd_controller;

    localparam int RC = 8;
    localparam int DW = 16;
    localparam int FW = RC * DW;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_ss;
    logic [7:0]    byte_out;
    logic          byte_ready;
    logic [FW-1:0] cfg_flat;
    logic          reg_we;
    logic [3:0]    reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [7:0]    err_count;
    logic [7:0]    cmd_count;

    spi_cmd_controller #(.REG_COUNT(RC), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .spi_ss(spi_ss), .byte_out(byte_out),
        .byte_ready(byte_ready), .cfg_flat(cfg_flat), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .err_count(err_count),
        .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-frame parsing with plain arithmetic.
    logic [DW-1:0] m_reg [RC];
    int            m_err, m_cmd;
    logic [3:0]    m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    ex_addr [$];
    logic [DW-1:0] ex_data [$];

    logic [3:0]    mon_addr  [$];
    logic [DW-1:0] mon_data  [$];
    logic [DW-1:0] mon_slice [$];

    always @(negedge clk) begin
        if (reg_we) begin
            mon_addr.push_back(reg_addr);
            mon_data.push_back(reg_wdata);
            mon_slice.push_back(cfg_flat[reg_addr*DW +: DW]);
        end
    end

    function automatic logic [FW-1:0] m_flat();
        logic [FW-1:0] f = '0;
        for (int i = 0; i < RC; i++) f[i*DW +: DW] = m_reg[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RC; i++) m_reg[i] = '0;
        m_err = 0; m_cmd = 0; m_addr = '0; m_wdata = '0;
        ex_addr.delete(); ex_data.delete();
    endtask

    task automatic model_frame(input logic [7:0] fb[$]);
        int i = 0;
        int a;
        logic [DW-1:0] w;
        while (i < fb.size()) begin
            logic [7:0] c = fb[i];
            i++;
            a = int'(c[3:0]);
            if (c == 8'h00) begin
                m_cmd = (m_cmd + 1) % 256;
            end else if (c[7:4] == 4'h2) begin
                for (int k = 0; k < RC; k++) m_reg[k] = '0;
                m_cmd = (m_cmd + 1) % 256;
            end else if (c[7:4] == 4'h1 && a < RC && i + NB <= fb.size()) begin
                w = '0;
                for (int k = 0; k < NB; k++) w = DW'(w * 256 + DW'(fb[i+k]));
                i += NB;
                m_reg[a] = w; m_addr = c[3:0]; m_wdata = w;
                ex_addr.push_back(c[3:0]); ex_data.push_back(w);
                m_cmd = (m_cmd + 1) % 256;
            end else begin
                // Bad opcode, bad address or truncated write: one error, rest of frame ignored.
                if (m_err < 255) m_err++;
                break;
            end
        end
    endtask

    task automatic do_reset(input bit hold_ready);
        @(negedge clk);
        rst = 1'b1; byte_ready = hold_ready; byte_out = 8'h00; spi_ss = !hold_ready;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        byte_ready = 1'b0; spi_ss = 1'b1;
        repeat (2) @(negedge clk);
        mon_addr.delete(); mon_data.delete(); mon_slice.delete();
    endtask

    task automatic check_frame(input string tag);
        check_val({tag, ".cfg"}, cfg_flat, m_flat());
        check_val({tag, ".err"}, FW'(err_count), FW'(m_err));
        check_val({tag, ".cmd"}, FW'(cmd_count), FW'(m_cmd));
        check_val({tag, ".addr"}, FW'(reg_addr), FW'(m_addr));
        check_val({tag, ".wdata"}, FW'(reg_wdata), FW'(m_wdata));
        check_val({tag, ".we_idle"}, FW'(reg_we), FW'(0));
        check_val({tag, ".nwrites"}, FW'(mon_addr.size()), FW'(ex_addr.size()));
        while (mon_addr.size() > 0 && ex_addr.size() > 0) begin
            logic [3:0]    ea = ex_addr.pop_front();
            logic [DW-1:0] ed = ex_data.pop_front();
            check_val({tag, ".w_addr"}, FW'(mon_addr.pop_front()), FW'(ea));
            check_val({tag, ".w_data"}, FW'(mon_data.pop_front()), FW'(ed));
            check_val({tag, ".w_cfg"}, FW'(mon_slice.pop_front()), FW'(ed));
        end
        mon_addr.delete(); mon_data.delete(); mon_slice.delete();
        ex_addr.delete(); ex_data.delete();
    endtask

    // ss_with_last raises spi_ss on the same cycle as the last byte's event.
    task automatic run_frame(input string tag, input logic [7:0] fb[$], input bit ss_with_last, input bit do_check);
        logic [7:0] mb[$];
        @(negedge clk) spi_ss = 1'b0;
        @(negedge clk);
        for (int k = 0; k < fb.size(); k++) begin
            @(negedge clk);
            byte_out = fb[k]; byte_ready = 1'b1;
            if (ss_with_last && k == fb.size() - 1) spi_ss = 1'b1;
            @(negedge clk) byte_ready = 1'b0;
        end
        @(negedge clk) spi_ss = 1'b1;
        repeat (2) @(negedge clk);
        mb = fb;
        if (ss_with_last && mb.size() > 0) void'(mb.pop_back());
        model_frame(mb);
        if (do_check) check_frame(tag);
    endtask

    initial begin
        logic [7:0] fq[$];
        rst = 1'b1; spi_ss = 1'b1; byte_out = '0; byte_ready = 1'b0;

        // byte_ready (with a NOP byte) held high across reset release must not count.
        do_reset(1'b1);
        check_frame("reset");

        fq = {8'h13, 8'hAB, 8'hCD};
        run_frame("wr3", fq, 1'b0, 1'b1);
        check_val("wr3.slice", FW'(cfg_flat[63:48]), FW'(16'hABCD));
        check_val("wr3.cmd_const", FW'(cmd_count), FW'(1));

        do_reset(1'b0);
        fq = {8'h10, 8'h12, 8'h34, 8'h00, 8'h17, 8'hFF, 8'hEE};
        run_frame("multi", fq, 1'b0, 1'b1);

        do_reset(1'b0);
        fq = {8'h12, 8'h55};
        run_frame("trunc", fq, 1'b0, 1'b1);
        check_val("trunc.err_const", FW'(err_count), FW'(1));
        fq = {8'h12, 8'h55, 8'h66};
        run_frame("after_trunc", fq, 1'b0, 1'b1);
        fq = {8'h11, 8'h99, 8'h77};
        run_frame("ss_on_last", fq, 1'b1, 1'b1);

        do_reset(1'b0);
        fq = {8'h18, 8'h01, 8'h02};
        run_frame("bad_addr", fq, 1'b0, 1'b1);
        fq = {8'h7F, 8'h10, 8'hAA, 8'hBB};
        run_frame("bad_op", fq, 1'b0, 1'b1);
        check_val("bad_op.err_const", FW'(err_count), FW'(2));

        fq = {};
        for (int r = 0; r < RC; r++) begin
            fq.push_back(8'h10 | 8'(r));
            for (int k = 0; k < NB; k++) fq.push_back(8'($urandom_range(1, 255)));
        end
        run_frame("fill", fq, 1'b0, 1'b1);
        fq = {8'h2F};
        run_frame("clear", fq, 1'b0, 1'b1);
        check_val("clear.zero", cfg_flat, '0);

        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 6);
            fq = {};
            for (int b = 0; b < len; b++) begin
                int sel = $urandom_range(0, 9);
                if (sel < 2) fq.push_back(8'h00);
                else if (sel < 6) begin
                    fq.push_back(8'h10 | 8'($urandom_range(0, (sel == 5) ? 15 : RC - 1)));
                    for (int k = 0; k < NB; k++) fq.push_back(8'($urandom));
                end else if (sel == 6) fq.push_back(8'h20 | 8'($urandom_range(0, 15)));
                else fq.push_back(8'($urandom));
            end
            run_frame($sformatf("rnd%0d", f), fq, ($urandom_range(0, 4) == 0), 1'b1);
        end

        for (int f = 0; f < 300; f++) begin
            fq = {8'hFF};
            run_frame("sat", fq, 1'b0, 1'b0);
        end
        check_frame("sat");
        check_val("sat.err_const", FW'(err_count), FW'(255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
